// File: rtl/regfile_pkg.sv
// Shared defaults, PC index helper and register-address type for the multi-port register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 16;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;

    // The top register index is never stored; it aliases the program counter.
    function automatic int pc_idx(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [DATA_W-1:0]        pc_plus_8;
    logic                     wa_en;
    logic [AW-1:0]            wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     sb_set_en;
    logic [AW-1:0]            sb_set_addr;
    logic [NUM_REGS-1:0]      busy_vec;
    logic                     pc_wr_valid;
    logic [DATA_W-1:0]        pc_wr_data;

    modport master (
        output rd_addr, pc_plus_8, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy, busy_vec, pc_wr_valid, pc_wr_data
    );

    modport slave (
        input  rd_addr, pc_plus_8, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, sb_set_en, sb_set_addr,
        output rd_data, rd_busy, busy_vec, pc_wr_valid, pc_wr_data
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Outstanding-load scoreboard: one busy bit per architectural register, the PC bit is held at zero.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    // A newly issued load outranks the writeback of an older one to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (set_en && set_addr == AW'(i)) begin
                    busy_vec[i] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(i)) begin
                    busy_vec[i] <= 1'b0;
                end
            end
            busy_vec[NUM_REGS-1] <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with PC aliasing, load scoreboard and two prioritised write ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 3
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam int            AW      = $clog2(NUM_REGS);
    localparam logic [AW-1:0] PC_ADDR = AW'(pc_idx(NUM_REGS));

    logic                wa_act;
    logic                wb_act;
    logic                sb_act;
    logic                wa_pc;
    logic                wb_pc;
    logic [NUM_REGS-1:0] busy_vec;
    logic                pc_wr_valid;
    logic [DATA_W-1:0]   pc_wr_data;
    logic [DATA_W-1:0]   regs [NUM_REGS-1];

    // Gating with rst_n keeps forwarding paths quiet while reset is held.
    assign wa_act = bus.wa_en & rst_n;
    assign wb_act = bus.wb_en & rst_n;
    assign sb_act = bus.sb_set_en & rst_n;
    assign wa_pc  = wa_act && (bus.wa_addr == PC_ADDR);
    assign wb_pc  = wb_act && (bus.wb_addr == PC_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (wa_act && bus.wa_addr == AW'(i)) begin
                    regs[i] <= bus.wa_data;
                end else if (wb_act && bus.wb_addr == AW'(i)) begin
                    regs[i] <= bus.wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_wr_valid <= 1'b0;
            pc_wr_data  <= '0;
        end else begin
            pc_wr_valid <= wa_pc | wb_pc;
            if (wa_pc) begin
                pc_wr_data <= bus.wa_data;
            end else if (wb_pc) begin
                pc_wr_data <= bus.wb_data;
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_act),
        .set_addr (bus.sb_set_addr),
        .clr_en   (wb_act),
        .clr_addr (bus.wb_addr),
        .busy_vec (busy_vec)
    );

    assign bus.busy_vec    = busy_vec;
    assign bus.pc_wr_valid = pc_wr_valid;
    assign bus.pc_wr_data  = pc_wr_data;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              busy_bit;

        assign addr = bus.rd_addr[k*AW +: AW];

        // The PC check comes last so it overrides any forwarded write data.
        always_comb begin
            data     = '0;
            busy_bit = busy_vec[addr];
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (addr == AW'(i)) begin
                    data = regs[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (wa_act && bus.wa_addr == addr) begin
                data = bus.wa_data;
            end else if (wb_act && bus.wb_addr == addr) begin
                data = bus.wb_data;
            end
            if (wb_act && bus.wb_addr == addr && !(sb_act && bus.sb_set_addr == addr)) begin
                busy_bit = 1'b0;
            end
`endif
            if (addr == PC_ADDR) begin
                data     = bus.pc_plus_8;
                busy_bit = 1'b0;
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = data;
        assign bus.rd_busy[k]                  = busy_bit;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MCU core: architectural registers R0..R(NUM_REGS-2), with the top index mapped to the PC. It provides NUM_RD combinational read ports and two prioritised write ports: A for ALU writeback and B for load writeback. A per-register scoreboard tracks outstanding loads, and writes to the PC index become a registered branch request. It sits between decode (reads and scoreboard set) and the execute/memory writeback stages.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of register indices; must be a power of two; index NUM_REGS-1 is the PC
- NUM_RD, 3, number of read ports
- AW, $clog2(NUM_REGS), address width (derived; not overridden)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*AW  packed read addresses, port k at bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  port k's register has a load outstanding
- pc_plus_8  in  DATA_W  value returned for any read of the PC index
- wa_en / wa_addr / wa_data  in  1 / AW / DATA_W  write port A (ALU)
- wb_en / wb_addr / wb_data  in  1 / AW / DATA_W  write port B (load); also clears the scoreboard bit
- sb_set_en / sb_set_addr  in  1 / AW  mark a register pending (load issued)
- busy_vec  out  NUM_REGS  scoreboard state; bit NUM_REGS-1 is always 0
- pc_wr_valid  out  1  one-cycle pulse: PC written in the previous cycle
- pc_wr_data  out  DATA_W  target of that PC write

## Operation
- Storage: NUM_REGS-1 registers of DATA_W bits. The PC is not stored.
- Read, port k:
  - address = NUM_REGS-1: returns pc_plus_8; rd_busy[k]=0
  - otherwise: returns the stored value; rd_busy[k] = busy_vec[addr]
- Write, non-PC address:
  - wa_en writes wa_data; wb_en writes wb_data.
  - Same address written by both ports in one cycle: port A wins (A is the younger instruction). The scoreboard is still cleared by B.
- Write, PC address:
  - Register file is unchanged.
  - Next cycle: pc_wr_valid=1 and pc_wr_data = written data. If both ports target the PC, A's data is used.
- Scoreboard:
  - sb_set_en to a non-PC address sets busy; sb_set_en to the PC address is ignored.
  - wb_en clears busy for wb_addr.
  - Set and clear of the same address in one cycle: set wins (a newer load has been issued).
  - Port A writes do not affect the scoreboard.
- Reset (rst_n low, any time, including mid-write): all registers 0, busy_vec 0, pc_wr_valid 0, pc_wr_data 0. All write and set inputs are ignored while rst_n is low.

## Timing
- Reads are combinational from stored state plus the optional bypass; they add no cycles.
- Writes: data is stored on the rising edge. Without bypass, the written data is readable in the cycle after the write.
- pc_wr_valid: high for exactly one cycle, the cycle after the PC write. Back-to-back PC writes produce consecutive pulses.
- busy_vec: updates on the rising edge; the new value is visible the cycle after sb_set_en / wb_en.
- Reset release: first write is accepted on the first rising edge with rst_n high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read matching a same-cycle write address returns the write data (A before B).
  - rd_busy is forced to 0 when wb_en clears that address in the same cycle, unless sb_set_en also targets it.
  - PC index reads still return pc_plus_8.
- REGFILE_BYPASS_EN undefined:
  - Reads return stored state and stored busy bits only.
  - Decode must stall one cycle after a dependent writeback.

## Structure
- Shared package regfile_pkg:
  - default DATA_W and NUM_REGS
  - pc_idx(NUM_REGS) function
  - reg-address typedef
- Sub-module regfile_scoreboard: the busy_vec register with set/clear priority and PC masking. It is instantiated once.
- Read ports are built with a generate loop over NUM_RD.

## Test plan
- Reset: hold rst_n=0 with wa_en=1, wa_addr=3 → all rd_data 0, busy_vec 0, pc_wr_valid 0. After release, write R3=0xDEADBEEF → read of 3 returns 0xDEADBEEF next cycle.
- Write conflict: same cycle wa_en R5=0x11, wb_en R5=0x22 → R5 reads 0x11; busy[5] cleared.
- Scoreboard: sb_set R7, then 3 idle cycles → rd_busy=1 for addr 7. wb_en R7=0x55 → busy 0 next cycle, data 0x55. Same-cycle set R7 + wb R7 → busy[7] stays 1.
- PC handling:
  - Read addr 15 with pc_plus_8=0x108 → 0x108.
  - wa_en addr 15 data 0x2000 → pc_wr_valid pulses one cycle with 0x2000; stored registers unchanged.
  - sb_set addr 15 → busy_vec unchanged.
- Bypass (REGFILE_BYPASS_EN): wa_en R2=0xA5 while reading R2 on all NUM_RD ports → 0xA5 the same cycle. Without the macro → old value, then 0xA5 the next cycle.
- Parameter sweep: NUM_REGS=32, DATA_W=64, NUM_RD=4. Random writes compared against a reference model over 10k cycles with an asynchronous reset pulse mid-run → no mismatches.
